// File: rtl/quad_root_solver_pkg.sv
// Shared types and width helpers for the quadratic root solver.
package quad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DISC,
    SQRT,
    DIV1,
    DIV2,
    DONE
  } state_t;

  localparam logic [1:0] ST_NONE   = 2'b00;
  localparam logic [1:0] ST_DOUBLE = 2'b01;
  localparam logic [1:0] ST_TWO    = 2'b10;
  localparam logic [1:0] ST_DEGEN  = 2'b11;

  // Discriminant width: B*B - 4*A*C never overflows 2W+2 signed bits.
  function automatic int dw_of(input int w);
    return 2 * w + 2;
  endfunction

  // Square-root result width, also the number of sqrt iterations.
  function automatic int sw_of(input int w, input int f);
    return w + f + 1;
  endfunction

  // Dividend magnitude width, also the number of divide iterations.
  function automatic int nw_of(input int w, input int f);
    return w + f + 2;
  endfunction

endpackage

// File: rtl/quad_root_solver_isqrt.sv
// Bit-serial integer square root: one result bit per cycle.
// The first iteration runs on the START edge straight from RADICAND, so a
// RW-bit radicand finishes RW/2 edges after START with DONE pulsing high
// for one cycle while ROOT holds floor(sqrt(RADICAND)).
module isqrt_seq
  import quad_pkg::*;
#(
  parameter int RW = 50
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic [RW-1:0]   RADICAND,
  output logic            BUSY,
  output logic            DONE,
  output logic [RW/2-1:0] ROOT
);

  localparam int HW = RW / 2;
  localparam int CW = $clog2(HW);

  logic [HW+1:0] rem_q;
  logic [RW-1:0] rad_q;
  logic [CW-1:0] cnt_q;

  logic [HW+1:0] rem_in, rem_shift, trial, rem_next;
  logic [HW-1:0] root_in, root_next;
  logic [RW-1:0] rad_in;
  logic          fits;

  // One digit-by-digit step; START restarts from an empty remainder.
  always_comb begin
    rem_in    = START ? '0 : rem_q;
    root_in   = START ? '0 : ROOT;
    rad_in    = START ? RADICAND : rad_q;
    rem_shift = (rem_in << 2) | {{HW{1'b0}}, rad_in[RW-1 -: 2]};
    trial     = {root_in, 2'b01};
    fits      = (rem_shift >= trial);
    rem_next  = fits ? (rem_shift - trial) : rem_shift;
    root_next = (root_in << 1) | {{(HW-1){1'b0}}, fits};
  end

  // Iteration registers and the done pulse after the final bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rem_q <= '0;
      rad_q <= '0;
      cnt_q <= '0;
      ROOT  <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (START) begin
        rem_q <= rem_next;
        rad_q <= rad_in << 2;
        ROOT  <= root_next;
        cnt_q <= CW'(HW - 1);
        BUSY  <= 1'b1;
      end else if (BUSY) begin
        rem_q <= rem_next;
        rad_q <= rad_in << 2;
        ROOT  <= root_next;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          BUSY <= 1'b0;
          DONE <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/quad_root_solver.sv
// Multi-cycle fixed-point quadratic solver with valid/ready handshakes.
// Optional macro QUAD_COMPLEX_ROOTS_EN: for D<0 report the real part in RT1
// and the imaginary magnitude in RT2 instead of zeros.
module quad_root_solver
  import quad_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic signed [W-1:0] A,
  input  logic signed [W-1:0] B,
  input  logic signed [W-1:0] C,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic signed [W-1:0] RT1,
  output logic signed [W-1:0] RT2,
  output logic [1:0]          ST,
  output logic                OVF
);

  localparam int DW = dw_of(W);
  localparam int SW = sw_of(W, FRAC);
  localparam int NW = nw_of(W, FRAC);
  localparam int CW = $clog2(NW);

`ifdef QUAD_COMPLEX_ROOTS_EN
  localparam bit CPLX_EN = 1'b1;
`else
  localparam bit CPLX_EN = 1'b0;
`endif

  localparam logic [NW-1:0] POS_LIM = NW'({(W-1){1'b1}});
  localparam logic [NW-1:0] NEG_LIM = POS_LIM + 1'b1;
  localparam logic [W-1:0]  MAX_V   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MIN_V   = {1'b1, {(W-1){1'b0}}};

  state_t state_q, state_d;

  logic signed [W-1:0] a_q, b_q, c_q;
  logic [W:0]          rem_q;
  logic [NW-1:0]       quo_q;
  logic [CW-1:0]       dcnt_q;
  logic                neg_q, double_q, cplx_q, ovf_w;
  logic [W-1:0]        rt1_w;
  logic [1:0]          st_w;

  logic signed [DW-1:0] a_dw, b_dw, c_dw, disc, abs_disc;
  logic                 disc_neg, disc_zero, a_zero;
  logic [2*SW-1:0]      sq_rad;
  logic [SW-1:0]        sq_root;
  logic                 sq_start, sq_busy, sq_done;

  logic signed [W:0]    a_ext, a_abs;
  logic [W:0]           den;
  logic signed [NW:0]   b_n, neg_b, s_ext, num1, num2, num_load;
  logic [NW-1:0]        num_mag;
  logic                 load_neg, div_last;

  logic [W+1:0]         rem_sh;
  logic [W:0]           rem_nx;
  logic [NW-1:0]        quo_nx;
  logic                 ge;
  logic [W-1:0]         sat_val;
  logic                 sat_ovf;

  isqrt_seq #(.RW(2 * SW)) u_isqrt (
    .CLK      (CLK),
    .RST      (RST),
    .START    (sq_start),
    .RADICAND (sq_rad),
    .BUSY     (sq_busy),
    .DONE     (sq_done),
    .ROOT     (sq_root)
  );

  // Discriminant, divisor magnitude and the two numerators -(B<<FRAC) +/- S.
  always_comb begin
    a_dw      = {{(DW-W){a_q[W-1]}}, a_q};
    b_dw      = {{(DW-W){b_q[W-1]}}, b_q};
    c_dw      = {{(DW-W){c_q[W-1]}}, c_q};
    disc      = b_dw * b_dw - ((a_dw * c_dw) <<< 2);
    disc_neg  = disc[DW-1];
    disc_zero = (disc == '0);
    a_zero    = (a_q == '0);
    abs_disc  = disc_neg ? -disc : disc;
    sq_rad    = (2 * SW)'(abs_disc) << (2 * FRAC);
    a_ext     = {a_q[W-1], a_q};
    a_abs     = a_ext[W] ? -a_ext : a_ext;
    den       = a_abs << 1;
    b_n       = {{(NW+1-W){b_q[W-1]}}, b_q};
    neg_b     = -(b_n <<< FRAC);
    s_ext     = (state_q == DISC) ? '0 : {{(NW+1-SW){1'b0}}, sq_root};
    num1      = cplx_q ? neg_b : (neg_b + s_ext);
    num2      = cplx_q ? s_ext : (neg_b - s_ext);
    num_load  = (state_q == DIV1) ? num2 : num1;
    num_mag   = NW'(num_load[NW] ? -num_load : num_load);
    load_neg  = num_load[NW] ^ (a_q[W-1] & ~(cplx_q & (state_q == DIV1)));
  end

  // One restoring-division step plus signed saturation of its quotient.
  always_comb begin
    rem_sh   = {rem_q, quo_q[NW-1]};
    ge       = (rem_sh >= {1'b0, den});
    rem_nx   = ge ? (W+1)'(rem_sh - {1'b0, den}) : rem_sh[W:0];
    quo_nx   = {quo_q[NW-2:0], ge};
    div_last = (dcnt_q == CW'(NW - 1));
    sat_val  = quo_nx[W-1:0];
    sat_ovf  = 1'b0;
    if (!neg_q) begin
      if (quo_nx > POS_LIM) begin
        sat_val = MAX_V;
        sat_ovf = 1'b1;
      end
    end else if (quo_nx > NEG_LIM) begin
      sat_val = MIN_V;
      sat_ovf = 1'b1;
    end else begin
      sat_val = -quo_nx[W-1:0];
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic, handshake flags and the sqrt kick-off.
  always_comb begin
    state_d   = state_q;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    sq_start  = 1'b0;
    case (state_q)
      IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) state_d = DISC;
      end
      DISC: begin
        if (a_zero || (disc_neg && !CPLX_EN)) state_d = DONE;
        else if (disc_zero)                   state_d = DIV1;
        else begin
          state_d  = SQRT;
          sq_start = 1'b1;
        end
      end
      SQRT: if (sq_done && !sq_busy) state_d = DIV1;
      DIV1: if (div_last) state_d = double_q ? DONE : DIV2;
      DIV2: if (div_last) state_d = DONE;
      DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Coefficient capture, divider iterations and publishing of the result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dcnt_q   <= '0;
      neg_q    <= 1'b0;
      double_q <= 1'b0;
      cplx_q   <= 1'b0;
      ovf_w    <= 1'b0;
      rt1_w    <= '0;
      st_w     <= ST_NONE;
      RT1      <= '0;
      RT2      <= '0;
      ST       <= ST_NONE;
      OVF      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (IN_VALID) begin
            a_q <= A;
            b_q <= B;
            c_q <= C;
          end
        end
        DISC: begin
          ovf_w    <= 1'b0;
          double_q <= disc_zero;
          cplx_q   <= CPLX_EN && disc_neg;
          if (a_zero || (disc_neg && !CPLX_EN)) begin
            RT1 <= '0;
            RT2 <= '0;
            ST  <= a_zero ? ST_DEGEN : ST_NONE;
            OVF <= 1'b0;
          end else begin
            st_w <= disc_neg ? ST_NONE : (disc_zero ? ST_DOUBLE : ST_TWO);
            if (disc_zero) begin
              rem_q  <= '0;
              quo_q  <= num_mag;
              neg_q  <= load_neg;
              dcnt_q <= '0;
            end
          end
        end
        SQRT: begin
          if (sq_done && !sq_busy) begin
            rem_q  <= '0;
            quo_q  <= num_mag;
            neg_q  <= load_neg;
            dcnt_q <= '0;
          end
        end
        DIV1: begin
          rem_q  <= rem_nx;
          quo_q  <= quo_nx;
          dcnt_q <= dcnt_q + 1'b1;
          if (div_last) begin
            rt1_w <= sat_val;
            ovf_w <= ovf_w | sat_ovf;
            if (double_q) begin
              RT1 <= sat_val;
              RT2 <= sat_val;
              ST  <= st_w;
              OVF <= ovf_w | sat_ovf;
            end else begin
              rem_q  <= '0;
              quo_q  <= num_mag;
              neg_q  <= load_neg;
              dcnt_q <= '0;
            end
          end
        end
        DIV2: begin
          rem_q  <= rem_nx;
          quo_q  <= quo_nx;
          dcnt_q <= dcnt_q + 1'b1;
          if (div_last) begin
            RT1 <= rt1_w;
            RT2 <= sat_val;
            ST  <= st_w;
            OVF <= ovf_w | sat_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
